// File: rtl/cache_mem_pkg.sv
// Shared types and default geometry for the L1 cache memory-side controller.
package cache_mem_pkg;

    localparam int unsigned LINE_W_DEF = 512;
    localparam int unsigned BEAT_W_DEF = 64;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned BEATS      = LINE_W_DEF / BEAT_W_DEF;
    localparam int unsigned OFF        = $clog2(LINE_W_DEF / 8);

    typedef logic [LINE_W_DEF-1:0] line_t;
    typedef logic [BEAT_W_DEF-1:0] beat_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_CMD  = 3'd1,
        WB_DATA = 3'd2,
        RF_CMD  = 3'd3,
        RF_DATA = 3'd4,
        RESP    = 3'd5
    } state_e;

endpackage

// File: rtl/line_beat_buf.sv
// One cache line held as a register, walked beat by beat through a shared counter.
// Beat 0 is the least significant slice; the counter clears on request and wraps after the last beat.
module line_beat_buf #(
    parameter int unsigned LINE_W = 512,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LINE_W-1:0] load_data_i,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic              wr_i,
    input  logic [BEAT_W-1:0] wr_data_i,
    output logic [BEAT_W-1:0] rd_data_o,
    output logic              last_o,
    output logic [LINE_W-1:0] line_nxt_o
);

    localparam int unsigned NBEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [LINE_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       beat_base;

    assign beat_base  = 32'(cnt_q) * BEAT_W;
    assign last_o     = (cnt_q == CNT_W'(NBEATS - 1));
    assign rd_data_o  = line_q[beat_base +: BEAT_W];
    assign line_nxt_o = line_d;

    // Next line: whole-line load wins over a single refill beat.
    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_data_i;
        end else if (wr_i) begin
            line_d[beat_base +: BEAT_W] = wr_data_i;
        end
    end

    // Beat counter: advances on any consumed/produced beat, never passes the last beat.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (adv_i || wr_i) begin
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Line and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_line_mem_ctrl.sv
// Memory-side controller for the L1 cache: optional dirty-victim writeback burst,
// then a line refill burst reassembled into one response.
// Optional macro CACHE_LINE_MEM_CTRL_TIMEOUT_EN adds an idle-wait abort with resp_err.
module cache_line_mem_ctrl
    import cache_mem_pkg::*;
#(
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned BEAT_W = BEAT_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
`ifdef CACHE_LINE_MEM_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [LINE_W-1:0] req_wb_data,
    input  logic [ADDR_W-1:0] req_fill_addr,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata
);

    localparam int unsigned LOFF = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << LOFF) - ADDR_W'(1));

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wb_addr_q, fill_addr_q;
    logic [LINE_W-1:0] resp_data_q;
    logic              accept, buf_clr, buf_adv, buf_wr, buf_last, fill_done, progress;
    logic [BEAT_W-1:0] buf_rd;
    logic [LINE_W-1:0] buf_nxt;

`ifdef CACHE_LINE_MEM_CTRL_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    logic              busy, abort, err_q;
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign busy = (state_q == WB_CMD) || (state_q == WB_DATA) ||
                  (state_q == RF_CMD) || (state_q == RF_DATA);
`endif

    line_beat_buf #(
        .LINE_W(LINE_W),
        .BEAT_W(BEAT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_data_i(req_wb_data),
        .clr_i      (buf_clr),
        .adv_i      (buf_adv),
        .wr_i       (buf_wr),
        .wr_data_i  (mem_rdata),
        .rd_data_o  (buf_rd),
        .last_o     (buf_last),
        .line_nxt_o (buf_nxt)
    );

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        buf_clr   = 1'b0;
        buf_adv   = 1'b0;
        buf_wr    = 1'b0;
        fill_done = 1'b0;
        progress  = 1'b0;
`ifdef CACHE_LINE_MEM_CTRL_TIMEOUT_EN
        abort     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_wb ? WB_CMD : RF_CMD;
                end
            end
            WB_CMD: begin
                if (mem_cmd_ready) begin
                    progress = 1'b1;
                    buf_clr  = 1'b1;
                    state_d  = WB_DATA;
                end
            end
            WB_DATA: begin
                if (mem_wready) begin
                    progress = 1'b1;
                    buf_adv  = 1'b1;
                    if (buf_last) state_d = RF_CMD;
                end
            end
            RF_CMD: begin
                if (mem_cmd_ready) begin
                    progress = 1'b1;
                    buf_clr  = 1'b1;
                    state_d  = RF_DATA;
                end
            end
            RF_DATA: begin
                if (mem_rvalid) begin
                    progress = 1'b1;
                    buf_wr   = 1'b1;
                    if (buf_last) begin
                        fill_done = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef CACHE_LINE_MEM_CTRL_TIMEOUT_EN
        if (busy && !progress && (wait_q == WAIT_W'(TIMEOUT - 1))) begin
            abort   = 1'b1;
            state_d = RESP;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request addresses, stored line-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_addr_q   <= '0;
            fill_addr_q <= '0;
        end else if (accept) begin
            wb_addr_q   <= req_wb_addr & ALIGN_MASK;
            fill_addr_q <= req_fill_addr & ALIGN_MASK;
        end
    end

    // Response line: captured with the final beat merged in, held until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data_q <= '0;
        end else if (fill_done) begin
            resp_data_q <= buf_nxt;
        end
`ifdef CACHE_LINE_MEM_CTRL_TIMEOUT_EN
        else if (abort) begin
            resp_data_q <= '0;
        end
`endif
    end

`ifdef CACHE_LINE_MEM_CTRL_TIMEOUT_EN
    // Idle-wait counter: restarts on state entry and on any handshake progress.
    always_comb begin
        wait_d = wait_q + WAIT_W'(1);
        if (!busy || progress || (state_d != state_q)) wait_d = '0;
    end

    // Wait counter and abort flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= abort;
        end
    end

    assign resp_err = (state_q == RESP) && err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready     = (state_q == IDLE);
    assign mem_cmd_valid = (state_q == WB_CMD) || (state_q == RF_CMD);
    assign mem_cmd_we    = (state_q == WB_CMD);
    assign mem_cmd_addr  = (state_q == WB_CMD) ? wb_addr_q :
                           (state_q == RF_CMD) ? fill_addr_q : '0;
    assign mem_wvalid    = (state_q == WB_DATA);
    assign mem_wdata     = mem_wvalid ? buf_rd : '0;
    assign resp_valid    = (state_q == RESP);
    assign resp_data     = resp_data_q;

endmodule

// File: tb/tb_cache_line_mem_ctrl.sv
// Scoreboard bench for cache_line_mem_ctrl: stimulus queues expected commands, write
// beats and responses; a negedge monitor pops and compares as the DUT presents them.
// Define CACHE_LINE_MEM_CTRL_TIMEOUT_EN to also exercise the timeout abort.
module tb_cache_line_mem_ctrl;

    typedef struct { logic we; logic [31:0] addr; } cmd_t;
    typedef struct { logic [511:0] data; logic err; int cyc; } resp_t;

    logic         clk, rst;
    logic         req_valid, req_ready, req_wb;
    logic [31:0]  req_wb_addr, req_fill_addr;
    logic [511:0] req_wb_data, resp_data;
    logic         resp_valid, resp_err;
    logic         mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [31:0]  mem_cmd_addr;
    logic         mem_wvalid, mem_wready, mem_rvalid;
    logic [63:0]  mem_wdata, mem_rdata;

    cmd_t         cmd_q[$];
    logic [63:0]  wbeat_q[$];
    resp_t        resp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int resp_seen  = 0;
    int wbeat_seen = 0;

    // memory model configuration
    logic [63:0] rd_base;
    logic        rd_gap, wr_toggle, no_read, spur;
    int          stall_left;
    logic [511:0] last_line;

`ifdef CACHE_LINE_MEM_CTRL_TIMEOUT_EN
    cache_line_mem_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data), .req_fill_addr(req_fill_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );
`else
    cache_line_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data), .req_fill_addr(req_fill_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
        return l;
    endfunction

    task automatic exp_cmd(input logic we, input logic [31:0] addr);
        cmd_t c;
        c.we = we;
        c.addr = addr;
        cmd_q.push_back(c);
    endtask

    task automatic exp_resp(input logic [511:0] data, input logic err, input int at);
        resp_t r;
        r.data = data;
        r.err = err;
        r.cyc = at;
        resp_q.push_back(r);
        last_line = data;
    endtask

    task automatic issue(input logic wb, input logic [31:0] wa, input logic [511:0] wd,
                         input logic [31:0] fa);
        req_valid = 1'b1;
        req_wb = wb;
        req_wb_addr = wa;
        req_wb_data = wd;
        req_fill_addr = fa;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string nm, input int n0);
        int i;
        i = 0;
        while (resp_seen == n0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        #1;
        if (resp_seen == n0) fail_now(nm);
    endtask

    // Memory model: read bursts stream after a read command, optional gaps and stalls.
    initial begin : mem_model
        logic rd_go, r_taken, rd_active, rd_skip;
        int   rd_idx;
        rd_active = 1'b0;
        rd_skip = 1'b0;
        rd_idx = 0;
        mem_cmd_ready = 1'b1;
        mem_wready = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            rd_go   = !rst && mem_cmd_valid && mem_cmd_ready && !mem_cmd_we && !no_read;
            r_taken = mem_rvalid && rd_active;
            if (mem_cmd_valid && !mem_cmd_ready && stall_left > 0) stall_left--;
            @(posedge clk);
            #2;
            if (r_taken) rd_idx++;
            if (rd_idx >= 8) rd_active = 1'b0;
            if (rd_go) begin
                rd_active = 1'b1;
                rd_idx = 0;
                rd_skip = 1'b0;
            end
            mem_cmd_ready = (stall_left == 0);
            mem_wready = wr_toggle ? !mem_wready : 1'b1;
            if (rd_active) begin
                mem_rvalid = !(rd_gap && rd_skip);
                mem_rdata = rd_base + 64'(rd_idx);
                rd_skip = !rd_skip;
            end else if (spur) begin
                mem_rvalid = 1'b1;
                mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                spur = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    // Monitor: reset values, handshake scoreboard, stall stability, response pulse.
    initial begin : monitor
        logic        p_cstall, p_cwe, p_wstall, p_resp;
        logic [31:0] p_caddr;
        logic [63:0] p_wdata;
        cmd_t        c;
        resp_t       r;
        logic [63:0] b;
        p_cstall = 0; p_cwe = 0; p_wstall = 0; p_resp = 0; p_caddr = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_ready", 512'(req_ready), 512'(1));
                chk("rst_cmd_valid", 512'(mem_cmd_valid), 512'(0));
                chk("rst_cmd_we", 512'(mem_cmd_we), 512'(0));
                chk("rst_cmd_addr", 512'(mem_cmd_addr), 512'(0));
                chk("rst_wvalid", 512'(mem_wvalid), 512'(0));
                chk("rst_wdata", 512'(mem_wdata), 512'(0));
                chk("rst_resp_valid", 512'(resp_valid), 512'(0));
                chk("rst_resp_err", 512'(resp_err), 512'(0));
                chk("rst_resp_data", resp_data, 512'(0));
                p_cstall = 0; p_wstall = 0; p_resp = 0;
            end else begin
                if (p_cstall) begin
                    chk("cmd_hold_valid", 512'(mem_cmd_valid), 512'(1));
                    chk("cmd_hold_we", 512'(mem_cmd_we), 512'(p_cwe));
                    chk("cmd_hold_addr", 512'(mem_cmd_addr), 512'(p_caddr));
                end
                if (p_wstall) begin
                    chk("w_hold_valid", 512'(mem_wvalid), 512'(1));
                    chk("w_hold_data", 512'(mem_wdata), 512'(p_wdata));
                end
                if (mem_cmd_valid && mem_cmd_ready) begin
                    if (cmd_q.size() == 0) fail_now("cmd_unexpected");
                    else begin
                        c = cmd_q.pop_front();
                        chk("cmd_we", 512'(mem_cmd_we), 512'(c.we));
                        chk("cmd_addr", 512'(mem_cmd_addr), 512'(c.addr));
                    end
                end
                if (mem_wvalid && mem_wready) begin
                    wbeat_seen++;
                    if (wbeat_q.size() == 0) fail_now("wbeat_unexpected");
                    else begin
                        b = wbeat_q.pop_front();
                        chk("wbeat_data", 512'(mem_wdata), 512'(b));
                    end
                end
                if (resp_valid) begin
                    resp_seen++;
                    chk("resp_pulse", 512'(p_resp), 512'(0));
                    chk("resp_req_ready", 512'(req_ready), 512'(0));
                    if (resp_q.size() == 0) fail_now("resp_unexpected");
                    else begin
                        r = resp_q.pop_front();
                        chk("resp_data", resp_data, r.data);
                        chk("resp_err", 512'(resp_err), 512'(r.err));
                        if (r.cyc >= 0) chk("resp_latency", 512'(cyc), 512'(r.cyc));
                    end
                end
                p_cstall = mem_cmd_valid && !mem_cmd_ready;
                p_cwe = mem_cmd_we;
                p_caddr = mem_cmd_addr;
                p_wstall = mem_wvalid && !mem_wready;
                p_wdata = mem_wdata;
                p_resp = resp_valid;
            end
        end
    end

    initial begin : stim
        int n0, i;
        rst = 1'b1;
        req_valid = 0; req_wb = 0; req_wb_addr = 0; req_wb_data = 0; req_fill_addr = 0;
        rd_base = 0; rd_gap = 0; wr_toggle = 0; no_read = 0; spur = 0; stall_left = 0;
        last_line = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // clean fill, minimum latency
        rd_base = 64'h0;
        exp_cmd(1'b0, 32'h0000_1200);
        exp_resp(mk_line(64'h0), 1'b0, cyc + 10);
        n0 = resp_seen;
        issue(1'b0, 32'h0, '0, 32'h0000_1234);
        wait_resp("t1_resp_timeout", n0);

        // writeback then fill
        rd_base = 64'hA5A5_0000_0000_0000;
        exp_cmd(1'b1, 32'h0000_2040);
        for (int k = 0; k < 8; k++) wbeat_q.push_back(64'hDEADBEEF_00000000 + 64'(k));
        exp_cmd(1'b0, 32'h0000_3000);
        exp_resp(mk_line(64'hA5A5_0000_0000_0000), 1'b0, cyc + 19);
        n0 = resp_seen;
        issue(1'b1, 32'h0000_2040, mk_line(64'hDEADBEEF_00000000), 32'h0000_3000);
        wait_resp("t2_resp_timeout", n0);

        // backpressure: command stall and toggling write ready
        rd_base = 64'h3333_0000_0000_0000;
        wr_toggle = 1'b1;
        stall_left = 3;
        exp_cmd(1'b1, 32'h0000_5040);
        for (int k = 0; k < 8; k++) wbeat_q.push_back(64'h1111_2222_0000_0000 + 64'(k));
        exp_cmd(1'b0, 32'h0000_6000);
        exp_resp(mk_line(64'h3333_0000_0000_0000), 1'b0, -1);
        n0 = resp_seen;
        issue(1'b1, 32'h0000_5078, mk_line(64'h1111_2222_0000_0000), 32'h0000_6004);
        wait_resp("t3_resp_timeout", n0);
        wr_toggle = 1'b0;

        // spurious read beat while idle, then gapped refill
        spur = 1'b1;
        @(posedge clk);
        #1;
        rd_base = 64'hC0DE_0000_0000_0000;
        rd_gap = 1'b1;
        exp_cmd(1'b0, 32'h0000_7FC0);
        exp_resp(mk_line(64'hC0DE_0000_0000_0000), 1'b0, -1);
        n0 = resp_seen;
        issue(1'b0, 32'h0, '0, 32'h0000_7FC0);
        wait_resp("t4_resp_timeout", n0);
        rd_gap = 1'b0;

        // reset after the fourth writeback beat
        exp_cmd(1'b1, 32'h0000_8000);
        for (int k = 0; k < 4; k++) wbeat_q.push_back(64'h5555_0000_0000_0000 + 64'(k));
        n0 = wbeat_seen;
        issue(1'b1, 32'h0000_8000, mk_line(64'h5555_0000_0000_0000), 32'h0000_9000);
        i = 0;
        while (wbeat_seen < n0 + 4 && i < 100) begin
            @(posedge clk);
            i++;
        end
        if (wbeat_seen < n0 + 4) fail_now("t5_beats_timeout");
        #1 rst = 1'b1;
        last_line = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // next request after reset completes normally
        rd_base = 64'h0F0F_0000_0000_0000;
        exp_cmd(1'b0, 32'h0000_A000);
        exp_resp(mk_line(64'h0F0F_0000_0000_0000), 1'b0, cyc + 10);
        n0 = resp_seen;
        issue(1'b0, 32'h0, '0, 32'h0000_A000);
        wait_resp("t6_resp_timeout", n0);

`ifdef CACHE_LINE_MEM_CTRL_TIMEOUT_EN
        // no read beats: abort 16 cycles after entering the data phase
        no_read = 1'b1;
        exp_cmd(1'b0, 32'h0000_B000);
        exp_resp('0, 1'b1, cyc + 18);
        n0 = resp_seen;
        issue(1'b0, 32'h0, '0, 32'h0000_B000);
        wait_resp("t7_resp_timeout", n0);
        no_read = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("resp_data_held", resp_data, last_line);
        chk("cmd_q_empty", 512'(cmd_q.size()), 512'(0));
        chk("wbeat_q_empty", 512'(wbeat_q.size()), 512'(0));
        chk("resp_q_empty", 512'(resp_q.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_mem_ctrl.md
Name: cache_line_mem_ctrl

Overview:
- Downstream memory-side controller for the 4-way set-associative L1 cache.
- Services the cache's miss/evict requests: an optional dirty-victim writeback, then a line refill.
- Serialises the cache's 512-bit line into BEAT_W-wide memory bursts and reassembles refill beats into one 512-bit line.
- Replaces the cache's internal simulated-memory path; the cache's ask_for_data drives req_valid.

Parameters:
- LINE_W, 512, cache line width in bits.
- BEAT_W, 64, memory data bus width in bits; LINE_W must be an integer multiple of it.
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, idle-wait cycles before an error response (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  cache request valid.
- req_ready  out  1  controller idle, can accept a request.
- req_wb  in  1  victim is dirty; write it back before the refill.
- req_wb_addr  in  ADDR_W  victim line address.
- req_wb_data  in  LINE_W  victim line data.
- req_fill_addr  in  ADDR_W  address of the missing line.
- resp_valid  out  1  one-cycle pulse: refill complete.
- resp_data  out  LINE_W  refilled line; valid while resp_valid is high.
- resp_err  out  1  transaction aborted; qualified by resp_valid.
- mem_cmd_valid  out  1  memory command valid.
- mem_cmd_ready  in  1  memory accepts the command.
- mem_cmd_we  out  1  1 = write burst, 0 = read burst.
- mem_cmd_addr  out  ADDR_W  line-aligned burst address.
- mem_wvalid  out  1  write beat valid.
- mem_wready  in  1  memory accepts the write beat.
- mem_wdata  out  BEAT_W  write beat data.
- mem_rvalid  in  1  read beat valid; no backpressure.
- mem_rdata  in  BEAT_W  read beat data.

Behaviour:
- Derived values:
  - BEATS = LINE_W/BEAT_W (8 by default).
  - OFF = log2(LINE_W/8) (6 by default).
  - mem_cmd_addr low OFF bits are forced to 0 (line-aligned).
- Reset, asynchronous: state IDLE, beat counter 0, line buffer 0. All outputs 0 except req_ready=1.
- A reset mid-transaction aborts immediately with no response. An outstanding memory burst is discarded, and any subsequent mem_rvalid outside RF_DATA is ignored.
- States:
  - IDLE: req_ready=1. On req_valid: latch all req_* fields, go to WB_CMD if req_wb, else RF_CMD.
  - WB_CMD: mem_cmd_valid=1, mem_cmd_we=1, addr = latched wb_addr. On mem_cmd_ready -> WB_DATA, beat counter = 0.
  - WB_DATA: mem_wvalid=1, mem_wdata = wb_data[beat*BEAT_W +: BEAT_W]. Beat 0 is the LSBs; order is ascending. Counter increments on mem_wvalid&&mem_wready. The last beat accepted -> RF_CMD.
  - RF_CMD: mem_cmd_valid=1, mem_cmd_we=0, addr = latched fill_addr. On mem_cmd_ready -> RF_DATA, counter = 0.
  - RF_DATA: each mem_rvalid writes mem_rdata into line[beat*BEAT_W +: BEAT_W] and increments the counter. Beat BEATS-1 received -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, resp_data = assembled line, resp_err=0. Then -> IDLE.
- resp_data holds its value until the next RESP. req_ready=0 in every state except IDLE.
- Minimum latency, no writeback, memory always ready and streaming:
  - Accept at edge 0; command handshake at cycle 1; beats at cycles 2..9; resp_valid at cycle 10.
  - A writeback adds 1 + BEATS cycles.
- Boundaries:
  - mem_cmd_valid, once asserted, holds along with its address until accepted.
  - mem_wvalid/mem_wdata hold until mem_wready.
  - The beat counter wraps only via a state exit; it never exceeds BEATS-1.
  - A new request is never accepted in the RESP cycle; the earliest re-accept is the following cycle.

Optional Feature:
- Macro CACHE_LINE_MEM_CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter runs in WB_CMD, WB_DATA, RF_CMD and RF_DATA.
  - It clears on any handshake progress (cmd accepted, write beat accepted, read beat received) and on state entry.
  - Reaching TIMEOUT -> RESP with resp_err=1 and resp_data=0.
- Undefined: the controller waits indefinitely, and resp_err is tied to 0.

Decomposition:
- Package cache_mem_pkg:
  - state enum: IDLE, WB_CMD, WB_DATA, RF_CMD, RF_DATA, RESP;
  - LINE_W/BEAT_W/ADDR_W defaults;
  - BEATS and OFF localparams;
  - line and beat typedefs.
- One sub-module, line_beat_buf: LINE_W register with a beat counter. Supports parallel load, beat-indexed read for writeback, beat-indexed write for refill, and a last-beat flag.

Test Plan:
- Clean fill: req_wb=0, fill_addr=0x0000_1234, mem_rdata beats 0..7 = 64'h0..7 every cycle, cmd_ready=1:
  - mem_cmd_addr=0x0000_1200, we=0;
  - resp_valid at cycle 10;
  - resp_data[63:0]=0, resp_data[511:448]=7.
- Writeback+fill: wb_addr=0x0000_2040, wb_data beat k = 64'hDEADBEEF_0000000k, fill_addr=0x0000_3000:
  - write command to 0x0000_2040 with 8 beats in ascending order;
  - then read command to 0x0000_3000;
  - one resp_valid pulse.
- Backpressure: mem_cmd_ready low 3 cycles, mem_wready toggling each cycle -> cmd/addr/wdata stay stable while stalled; no beat skipped or repeated.
- Gapped refill: mem_rvalid on alternate cycles, plus spurious mem_rvalid in IDLE -> line correct, spurious beat ignored, resp_valid 1 cycle.
- Reset mid-WB_DATA after beat 3 -> all outputs reset, req_ready=1 next cycle; the next request completes normally.
- With the macro and TIMEOUT=16, no mem_rvalid after cmd accept -> resp_valid with resp_err=1, resp_data=0 exactly 16 cycles after RF_DATA entry.
